ofmap_accumulator: RTL
======================

# ofmap_accumulator

Output stage directly downstream of the systolic array. Captures the column-skewed partial sums leaving the array's bottom row, deskews them with per-column delayed control, and accumulates them across input-channel passes into an OX0*OY0 tile buffer. After the last pass it drains the completed tile as aligned ARRAY_WIDTH-wide vectors over a valid/ready interface.

## Interface
- OFMAP_WIDTH, 32, width of every partial sum and accumulator entry
- ARRAY_WIDTH, 4, number of columns/lanes; must match the systolic array
- ACCUM_DEPTH, 16, tile entries per lane (OX0*OY0)
- ADDR_WIDTH, $clog2(ACCUM_DEPTH), entry address width
- clk  input  1  single clock; all state updates on its rising edge
- rst  input  1  reset, synchronous and active-high
- en  input  1  global enable; low freezes all state and holds all outputs
- in_valid  input  1  column-0 element of ofmap_in is valid this cycle
- in_first  input  1  qualifies in_valid; vector belongs to the first pass (overwrite, do not add)
- in_last  input  1  qualifies in_valid; vector belongs to the last pass (tile completes)
- ofmap_in  input  signed OFMAP_WIDTH x ARRAY_WIDTH  systolic array ofmap_out; lane c lags lane 0 by c cycles
- in_ready  output  1  block accepts in_valid
- out_valid  output  1  ofmap_out holds one completed tile entry
- out_ready  input  1  downstream accepts ofmap_out
- ofmap_out  output  signed OFMAP_WIDTH x ARRAY_WIDTH  drained, lane-aligned tile entry
- overflow_err  output  1  sticky; in_valid seen while in_ready low

## Operation
- States: ACCUM, CLOSING, DRAIN. Reset -> ACCUM.
- ACCUM: each accepted in_valid (en && in_valid && in_ready) pushes {valid, wr_addr, first, last} into a control delay chain; wr_addr increments, wraps ACCUM_DEPTH-1 -> 0.
- Lane c uses chain stage c (lane 0 undelayed). At that stage: first=1 -> bank[c][addr] = ofmap_in[c]; else bank[c][addr] += ofmap_in[c].
- Addition wraps modulo 2^OFMAP_WIDTH (two's complement), unless saturation is compiled in.
- in_first and in_last both high: single-pass tile; overwrite, then drain.
- Accepting in_last at wr_addr = ACCUM_DEPTH-1 -> CLOSING; in_ready drops the next cycle.
- CLOSING: chain drains; when lane ARRAY_WIDTH-1 completes its write of addr ACCUM_DEPTH-1 -> DRAIN.
- DRAIN: rd_addr 0..ACCUM_DEPTH-1; output register loads all lanes of bank[*][rd_addr] when !out_valid || out_ready; rd_addr increments on each load.
- Handshake at out_valid && out_ready; data and out_valid held stable while out_ready low.
- Final handshake (addr ACCUM_DEPTH-1) -> ACCUM, wr_addr = 0, in_ready high next cycle.
- in_valid while in_ready low: vector ignored, overflow_err set; cleared only by rst.
- Bank contents are not reset; the first pass overwrites.

## Timing
- Reset values: in_ready 1, out_valid 0, ofmap_out all 0, overflow_err 0, wr_addr 0, rd_addr 0.
- Lane c write completes c cycles after lane-0 acceptance; same-address read-after-write between passes is safe since ACCUM_DEPTH >= ARRAY_WIDTH (elaboration check).
- Final lane write on edge E -> DRAIN after E -> first out_valid after edge E+1.
- Drain throughput: one entry per cycle with out_ready held high; ACCUM_DEPTH cycles per tile.
- en low mid-operation: chain, counters, banks and output register frozen; resumes exactly where it stopped.
- rst mid-accumulate or mid-drain: tile abandoned, state ACCUM, outputs to reset values next cycle.

## Configuration
- OFMAP_ACCUM_SATURATE_EN defined: accumulate clamps to [-2^(OFMAP_WIDTH-1), 2^(OFMAP_WIDTH-1)-1].
- Not defined: plain wrap-around addition.
- Overwrite (first pass) is unaffected either way.

## Structure
- Package ofmap_accumulator_pkg: state enum (ACCUM, CLOSING, DRAIN), control-chain struct {valid, addr, first, last}, saturating-add function.
- One sub-module, accum_bank: single lane's ACCUM_DEPTH x OFMAP_WIDTH register array with overwrite/accumulate write port and combinational read port; instantiated ARRAY_WIDTH times by generate.

## Test plan
- W=4, D=4, single pass (first=last=1), lane c entry a = 10*a+c, skewed -> drain emits {0,1,2,3},{10,11,12,13},{20..23},{30..33}, out_valid first high 2 edges after final lane-3 write.
- Three passes, each value 5 -> every drained lane = 15; second tile with first=1 shows no carry-over from the first.
- out_ready toggled 1,0,0,1 during drain -> no entry lost or duplicated; ofmap_out stable while stalled.
- in_valid during DRAIN -> ignored, overflow_err = 1 until rst; drained data unchanged.
- Accumulate 0x7FFFFFFF + 1 -> 0x80000000 without macro; 0x7FFFFFFF with OFMAP_ACCUM_SATURATE_EN.
- rst asserted mid-drain with out_valid high -> out_valid 0, in_ready 1 next cycle; fresh single-pass tile drains correctly.

Source files
------------

// File: rtl/ofmap_accumulator_pkg.sv
// Shared types for the ofmap accumulator: FSM states, deskew control record, saturating add.
// The saturating add is only used when OFMAP_ACCUM_SATURATE_EN is defined.
package ofmap_accumulator_pkg;

  // Control records carry a fixed-width address; the top checks ADDR_WIDTH fits.
  localparam int unsigned CtrlAddrWidth = 16;

  typedef enum logic [1:0] {
    StAccum,
    StClosing,
    StDrain
  } state_e;

  typedef struct packed {
    logic                     valid;
    logic [CtrlAddrWidth-1:0] addr;
    logic                     first;
    logic                     last;
  } ctrl_t;

  function automatic logic signed [63:0] sat_add(input logic signed [63:0] a,
                                                 input logic signed [63:0] b,
                                                 input int unsigned        width);
    logic signed [63:0] total;
    logic signed [63:0] max_v;
    logic signed [63:0] min_v;
    logic signed [63:0] result;
    total  = a + b;
    max_v  = (64'sd1 <<< (width - 1)) - 64'sd1;
    min_v  = -(64'sd1 <<< (width - 1));
    result = total;
    if (total > max_v) begin
      result = max_v;
    end else if (total < min_v) begin
      result = min_v;
    end
    return result;
  endfunction

endpackage

// File: rtl/ofmap_accumulator_accum_bank.sv
// One lane of the tile buffer: overwrite/accumulate write port, combinational read port.
// Accumulation saturates when OFMAP_ACCUM_SATURATE_EN is defined, otherwise wraps.
module accum_bank
  import ofmap_accumulator_pkg::*;
#(
  parameter int unsigned OFMAP_WIDTH = 32,
  parameter int unsigned ACCUM_DEPTH = 16,
  parameter int unsigned ADDR_WIDTH  = $clog2(ACCUM_DEPTH)
) (
  input  logic                          clk,
  input  logic                          we,
  input  logic                          first,
  input  logic [ADDR_WIDTH-1:0]         waddr,
  input  logic signed [OFMAP_WIDTH-1:0] wdata,
  input  logic [ADDR_WIDTH-1:0]         raddr,
  output logic signed [OFMAP_WIDTH-1:0] rdata
);

  logic signed [OFMAP_WIDTH-1:0] mem_q [ACCUM_DEPTH];
  logic signed [OFMAP_WIDTH-1:0] acc;

  always_comb begin
    acc = '0;
`ifdef OFMAP_ACCUM_SATURATE_EN
    acc = OFMAP_WIDTH'(sat_add(64'(mem_q[waddr]), 64'(wdata), OFMAP_WIDTH));
`else
    acc = mem_q[waddr] + wdata;
`endif
  end

  // Contents are deliberately not reset: the first pass of every tile overwrites.
  always_ff @(posedge clk) begin
    if (we) begin
      mem_q[waddr] <= first ? wdata : acc;
    end
  end

  assign rdata = mem_q[raddr];

endmodule

// File: rtl/ofmap_accumulator.sv
// Deskews systolic-array partial sums, accumulates them over passes, drains the tile.
// Define OFMAP_ACCUM_SATURATE_EN for clamping accumulation instead of wrap-around.
module ofmap_accumulator
  import ofmap_accumulator_pkg::*;
#(
  parameter int unsigned OFMAP_WIDTH = 32,
  parameter int unsigned ARRAY_WIDTH = 4,
  parameter int unsigned ACCUM_DEPTH = 16,
  parameter int unsigned ADDR_WIDTH  = $clog2(ACCUM_DEPTH)
) (
  input  logic                                           clk,
  input  logic                                           rst,
  input  logic                                           en,
  input  logic                                           in_valid,
  input  logic                                           in_first,
  input  logic                                           in_last,
  input  logic signed [ARRAY_WIDTH-1:0][OFMAP_WIDTH-1:0] ofmap_in,
  output logic                                           in_ready,
  output logic                                           out_valid,
  input  logic                                           out_ready,
  output logic signed [ARRAY_WIDTH-1:0][OFMAP_WIDTH-1:0] ofmap_out,
  output logic                                           overflow_err
);

  localparam logic [ADDR_WIDTH-1:0]    LastAddr     = ADDR_WIDTH'(ACCUM_DEPTH - 1);
  localparam logic [CtrlAddrWidth-1:0] LastCtrlAddr = CtrlAddrWidth'(ACCUM_DEPTH - 1);

  // Lane c rewrites an address c cycles late, so the next pass must not reach it sooner.
  if (ACCUM_DEPTH < ARRAY_WIDTH) begin : g_depth_chk
    $error("ACCUM_DEPTH must be >= ARRAY_WIDTH");
  end
  if (ARRAY_WIDTH < 2 || ADDR_WIDTH > CtrlAddrWidth) begin : g_width_chk
    $error("ARRAY_WIDTH must be >= 2 and ADDR_WIDTH must fit the control record");
  end

  state_e                                state_q;
  logic [ADDR_WIDTH-1:0]                 wr_addr_q;
  logic [ADDR_WIDTH-1:0]                 rd_addr_q;
  logic                                  rd_done_q;
  logic                                  in_ready_q;
  logic                                  out_valid_q;
  logic                                  overflow_q;
  logic [ARRAY_WIDTH-1:0][OFMAP_WIDTH-1:0] ofmap_out_q;
  logic [ARRAY_WIDTH-1:0][OFMAP_WIDTH-1:0] rd_data;
  ctrl_t                                 chain_q [ARRAY_WIDTH-1];
  ctrl_t                                 stage   [ARRAY_WIDTH];
  logic                                  accept;
  logic                                  last_lane_done;

  assign accept = en && in_valid && in_ready_q;

  // Stage 0 is the live input; stage k is the control record k cycles old.
  always_comb begin
    stage[0].valid = accept;
    stage[0].addr  = CtrlAddrWidth'(wr_addr_q);
    stage[0].first = in_first;
    stage[0].last  = in_last;
    for (int k = 1; k < ARRAY_WIDTH; k++) begin
      stage[k] = chain_q[k-1];
    end
  end

  assign last_lane_done = stage[ARRAY_WIDTH-1].valid && stage[ARRAY_WIDTH-1].last &&
                          (stage[ARRAY_WIDTH-1].addr == LastCtrlAddr);

  for (genvar c = 0; c < ARRAY_WIDTH; c++) begin : g_lane
    accum_bank #(
      .OFMAP_WIDTH(OFMAP_WIDTH),
      .ACCUM_DEPTH(ACCUM_DEPTH),
      .ADDR_WIDTH (ADDR_WIDTH)
    ) u_bank (
      .clk  (clk),
      .we   (en && !rst && stage[c].valid),
      .first(stage[c].first),
      .waddr(stage[c].addr[ADDR_WIDTH-1:0]),
      .wdata(ofmap_in[c]),
      .raddr(rd_addr_q),
      .rdata(rd_data[c])
    );
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= StAccum;
      wr_addr_q   <= '0;
      rd_addr_q   <= '0;
      rd_done_q   <= 1'b0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      ofmap_out_q <= '0;
      overflow_q  <= 1'b0;
      for (int k = 0; k < ARRAY_WIDTH - 1; k++) begin
        chain_q[k] <= '0;
      end
    end else if (en) begin
      if (in_valid && !in_ready_q) begin
        overflow_q <= 1'b1;
      end
      for (int k = 0; k < ARRAY_WIDTH - 1; k++) begin
        chain_q[k] <= stage[k];
      end
      unique case (state_q)
        StAccum: begin
          if (accept) begin
            wr_addr_q <= (wr_addr_q == LastAddr) ? '0 : wr_addr_q + 1'b1;
            if (in_last && (wr_addr_q == LastAddr)) begin
              state_q    <= StClosing;
              in_ready_q <= 1'b0;
            end
          end
        end
        StClosing: begin
          if (last_lane_done) begin
            state_q <= StDrain;
          end
        end
        StDrain: begin
          if (out_valid_q && out_ready && rd_done_q) begin
            state_q     <= StAccum;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
            rd_addr_q   <= '0;
            rd_done_q   <= 1'b0;
            wr_addr_q   <= '0;
          end else if ((!out_valid_q || out_ready) && !rd_done_q) begin
            ofmap_out_q <= rd_data;
            out_valid_q <= 1'b1;
            rd_done_q   <= (rd_addr_q == LastAddr);
            rd_addr_q   <= (rd_addr_q == LastAddr) ? '0 : rd_addr_q + 1'b1;
          end
        end
        default: state_q <= StAccum;
      endcase
    end
  end

  assign in_ready     = in_ready_q;
  assign out_valid    = out_valid_q;
  assign ofmap_out    = ofmap_out_q;
  assign overflow_err = overflow_q;

endmodule
